sync_adder_stim_chk: RTL and testbench

Synthesizable initiator and checker for the team's sync_adder, the other end of its enable/a/b -> sum/valid interface.
- Generates num_ops pseudo-random operand pairs, one per cycle, on op_a/op_b/op_en.
- Keeps an expected-result pipeline aligned to the adder latency and compares it against dut_sum/dut_valid.
- Reports pass/error counts and done.
- Used as a self-checking harness in simulation and as an on-chip BIST wrapper.

---
 rtl/sync_adder_pkg.sv | 10 +
 rtl/lfsr16.sv | 18 +
 rtl/sync_adder_stim_chk.sv | 129 ++++++++++++
 tb/tb_sync_adder_stim_chk.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_adder_pkg.sv
// sync_adder_pkg: shared LFSR, FSM and counter definitions for sync_adder stimulus/check blocks
package sync_adder_pkg;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? (v >> 1) ^ LFSR_POLY : v >> 1;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit right-shifting Galois LFSR with seed reload and single-step advance
module lfsr16
  import sync_adder_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [15:0] value
);
  // load wins over step so a restart always begins from the seed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= SEED;
    else if (load) value <= SEED;
    else if (step) value <= lfsr_next(value);
endmodule

// File: rtl/sync_adder_stim_chk.sv
// sync_adder_stim_chk: drives random operand pairs into sync_adder and checks its results; STIM_CORNER_CASES_EN prepends four fixed corner pairs
module sync_adder_stim_chk
  import sync_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LATENCY = 1,
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      num_ops,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_en,
  input  logic [WIDTH:0]   dut_sum,
  input  logic             dut_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int SW = WIDTH + 1;
  state_t state;
  logic [15:0] lfsr, lfsr_nx, n_ops, cnt;
  logic [3:0] dcnt;
  logic [LATENCY-1:0] exp_v;
  logic [SW-1:0] exp_s [LATENCY];
  logic accept, last, step, chk, hit, bad;
  logic [WIDTH-1:0] nxt_a, nxt_b;

  assign accept = start && (state == IDLE || state == DONE);
  assign last = op_en && (cnt + 16'd1 == n_ops);
  assign lfsr_nx = accept ? SEED : step ? lfsr_next(lfsr) : lfsr;

`ifdef STIM_CORNER_CASES_EN
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  logic [15:0] pidx;
  assign pidx = accept ? 16'd0 : cnt + 16'd1;
  assign step = op_en && cnt > 16'd3;
  // the operand pair prepared for the next op is a corner pair for op indices 0..3
  always_comb begin
    nxt_a = lfsr_nx[WIDTH-1:0];
    nxt_b = lfsr_nx[15 -: WIDTH];
    if (pidx < 16'd4) begin
      nxt_a = pidx[1:0] == 2'd1 ? MAX : pidx[1:0] == 2'd3 ? MSB : '0;
      nxt_b = pidx[1:0] == 2'd0 ? '0 : pidx[1:0] == 2'd3 ? MSB : MAX;
    end
  end
`else
  assign step = op_en;
  assign nxt_a = lfsr_nx[WIDTH-1:0];
  assign nxt_b = lfsr_nx[15 -: WIDTH];
`endif

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .step (step),
    .value(lfsr)
  );

  // expected results ride alongside the adder so the head lines up with dut_valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exp_v <= '0;
      for (int i = 0; i < LATENCY; i++) exp_s[i] <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        exp_v[i] <= exp_v[i-1];
        exp_s[i] <= exp_s[i-1];
      end
      exp_v[0] <= op_en;
      exp_s[0] <= SW'(op_a) + SW'(op_b);
    end

  assign chk = state == RUN || state == DRAIN;
  assign hit = chk && exp_v[LATENCY-1] && dut_valid && dut_sum == exp_s[LATENCY-1];
  assign bad = chk && (exp_v[LATENCY-1] ? !(dut_valid && dut_sum == exp_s[LATENCY-1]) : dut_valid);

  // control FSM: operand issue, drain of in-flight results and saturating tallies
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op_a <= '0;
      op_b <= '0;
      op_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass_cnt <= '0;
      err_cnt <= '0;
      n_ops <= '0;
      cnt <= '0;
      dcnt <= '0;
    end else begin
      pass_cnt <= hit && pass_cnt != '1 ? pass_cnt + 1'b1 : pass_cnt;
      err_cnt <= bad && err_cnt != '1 ? err_cnt + 1'b1 : err_cnt;
      if (accept || op_en) begin
        op_a <= nxt_a;
        op_b <= nxt_b;
      end
      if (accept) begin
        pass_cnt <= '0;
        err_cnt <= '0;
        n_ops <= num_ops;
        cnt <= '0;
        dcnt <= '0;
        state <= num_ops != 16'd0 ? RUN : DONE;
        op_en <= num_ops != 16'd0;
        busy <= num_ops != 16'd0;
        done <= num_ops == 16'd0;
      end else if (op_en) begin
        cnt <= cnt + 16'd1;
        if (last) begin
          state <= DRAIN;
          op_en <= 1'b0;
        end
      end else if (state == DRAIN) begin
        dcnt <= dcnt + 4'd1;
        if (dcnt == 4'(LATENCY)) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_sync_adder_stim_chk.sv
// tb_sync_adder_stim_chk: drives sync_adder_stim_chk against behavioural adder models and scores its operands and tallies
module tb_sync_adder_stim_chk;
  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic [15:0] num_ops = 0;
  logic [7:0] op_a, op_b;
  logic op_en, busy, done;
  logic [8:0] dut_sum = 0;
  logic dut_valid = 0;
  logic [15:0] pass_cnt, err_cnt;
  int mode = 0;
  int res_n = 0;
  logic extra_done = 0;
  int errors = 0;
  int checks = 0;
  logic [15:0] q[$];

  sync_adder_stim_chk dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops),
    .op_a(op_a), .op_b(op_b), .op_en(op_en),
    .dut_sum(dut_sum), .dut_valid(dut_valid),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // adder model, LATENCY=1; mode 1 flips sum bit 0, mode 2 drops the 3rd result and adds one spurious valid
  always @(posedge clk) begin
    dut_sum <= ({1'b0, op_a} + {1'b0, op_b}) ^ (mode == 1 ? 9'd1 : 9'd0);
    dut_valid <= op_en && !(mode == 2 && res_n == 2);
    res_n <= start ? 0 : op_en ? res_n + 1 : res_n;
    if (start) extra_done <= 0;
    if (mode == 2 && !op_en && res_n == 5 && !extra_done) begin
      dut_valid <= 1;
      extra_done <= 1;
    end
  end

  function automatic void gen(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    q.delete();
    for (int i = 0; i < n; i++) begin
`ifdef STIM_CORNER_CASES_EN
      if (i < 4) begin
        q.push_back(i == 0 ? 16'h0000 : i == 1 ? 16'hFFFF : i == 2 ? 16'h00FF : 16'h8080);
        continue;
      end
`endif
      q.push_back({l[7:0], l[15:8]});
      l = l[0] ? (l >> 1) ^ 16'hB400 : l >> 1;
    end
  endfunction

  task automatic run(input logic [15:0] n, input int m, output int en_cyc, output int dn_cyc, output logic [15:0] first_ab);
    logic [15:0] e;
    mode = m;
    en_cyc = 0;
    dn_cyc = -1;
    first_ab = 16'hxxxx;
    gen(int'(n));
    start = 1;
    num_ops = n;
    @(negedge clk);
    start = 0;
    for (int c = 1; c <= int'(n) + 40 && dn_cyc < 0; c++) begin
      if (op_en) begin
        if (en_cyc == 0) first_ab = {op_a, op_b};
        en_cyc++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_op: op_en high with no expected op, got a=%h b=%h", op_a, op_b);
        end else begin
          e = q.pop_front();
          if ({op_a, op_b} !== e) begin
            errors++;
            $display("FAIL operands op%0d: got a=%h b=%h expected a=%h b=%h", en_cyc, op_a, op_b, e[15:8], e[7:0]);
          end
        end
      end
      if (done) dn_cyc = c;
      else @(negedge clk);
    end
    checks++;
    if (dn_cyc < 0 || q.size() != 0) begin
      errors++;
      $display("FAIL completion: done_cycle=%0d ops_left=%0d expected done and 0 left", dn_cyc, q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({op_en, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: en/busy/done=%b expected 000", {op_en, busy, done});
    end
    checks++;
    if ({op_a, op_b, pass_cnt, err_cnt} !== 48'd0) begin
      errors++;
      $display("FAIL reset_data: a=%h b=%h pass=%0d err=%0d expected all 0", op_a, op_b, pass_cnt, err_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int en_c, dn_c;
    logic [15:0] f;
    run(16'd4, 0, en_c, dn_c, f);
    checks++;
`ifdef STIM_CORNER_CASES_EN
    if (f !== 16'h0000) begin
`else
    if (f !== 16'hE1AC) begin
`endif
      errors++;
      $display("FAIL first_op: got a/b=%h", f);
    end
    checks++;
    if (en_c !== 4) begin
      errors++;
      $display("FAIL en_cycles: got %0d expected 4", en_c);
    end
    checks++;
    if (dn_c < 1 || dn_c > 7) begin
      errors++;
      $display("FAIL done_latency: got %0d expected 1..7", dn_c);
    end
    checks++;
    if (pass_cnt !== 16'd4 || err_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_counts: pass=%0d err=%0d busy=%b expected 4 0 0", pass_cnt, err_cnt, busy);
    end
  endtask

  task automatic test_zero();
    int en_c, dn_c;
    logic [15:0] f;
    run(16'd0, 0, en_c, dn_c, f);
    checks++;
    if (dn_c !== 1 || en_c !== 0) begin
      errors++;
      $display("FAIL zero_ops: done_cycle=%0d en_cycles=%0d expected 1 0", dn_c, en_c);
    end
    checks++;
    if (pass_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL zero_counts: pass=%0d err=%0d expected 0 0", pass_cnt, err_cnt);
    end
  endtask

  task automatic test_bad_sum();
    int en_c, dn_c;
    logic [15:0] f;
    run(16'd10, 1, en_c, dn_c, f);
    checks++;
    if (pass_cnt !== 16'd0 || err_cnt !== 16'd10) begin
      errors++;
      $display("FAIL bad_sum: pass=%0d err=%0d expected 0 10", pass_cnt, err_cnt);
    end
  endtask

  task automatic test_drop_extra();
    int en_c, dn_c;
    logic [15:0] f;
    run(16'd5, 2, en_c, dn_c, f);
    checks++;
    if (pass_cnt !== 16'd4 || err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL drop_extra: pass=%0d err=%0d expected 4 2", pass_cnt, err_cnt);
    end
    mode = 0;
  endtask

  task automatic test_reset_mid();
    int en_c, dn_c;
    logic [15:0] f;
    logic seen;
    start = 1;
    num_ops = 16'd8;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    checks++;
    if (op_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run: en=%b busy=%b expected 1 1", op_en, busy);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({op_en, busy, done, op_a, op_b, pass_cnt, err_cnt} !== 51'd0) begin
      errors++;
      $display("FAIL async_reset: en=%b busy=%b done=%b a=%h b=%h pass=%0d err=%0d expected all 0",
               op_en, busy, done, op_a, op_b, pass_cnt, err_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= done | busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: done_or_busy_seen=%b expected 0", seen);
    end
    run(16'd6, 0, en_c, dn_c, f);
    checks++;
    if (en_c !== 6 || pass_cnt !== 16'd6 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL restart: en=%0d pass=%0d err=%0d expected 6 6 0", en_c, pass_cnt, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int en_c, dn_c;
    logic [15:0] f;
    run(16'd3, 0, en_c, dn_c, f);
    run(16'd7, 0, en_c, dn_c, f);
    checks++;
    if (en_c !== 7 || pass_cnt !== 16'd7 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL back_to_back: en=%0d pass=%0d err=%0d expected 7 7 0", en_c, pass_cnt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_bad_sum();
    test_drop_extra();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
